battle_controller: RTL and testbench

BATTLE_CONTROLLER -- requirements
Module: battle_controller

---
 rtl/battle_controller.sv | 195 +++++++++++++++++++
 tb/tb_battle_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/battle_controller.sv
// Shot controller for a battleship-style game: validates fire requests, issues
// one shot at a time to an external scorer and accumulates the results.
module battle_controller #(
    parameter int unsigned MAX_SHOTS = 40,
    parameter int unsigned BIG_BOMBS = 2,
    parameter int unsigned WIN_HITS  = 19
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       BigReq,
    input  logic       Fire,
    input  logic       Hit,
    input  logic       nearMiss,
    input  logic       Miss,
    input  logic [3:0] TotalHits,
    input  logic [4:0] BiggestShipHit,
    input  logic       SomethingIsWrong,
    output logic       ScoreThis,
    output logic [3:0] ShotX,
    output logic [3:0] ShotY,
    output logic       Big,
    output logic [1:0] BigLeft,
    output logic [6:0] Score,
    output logic [6:0] ShotsFired,
    output logic [4:0] ShipsTouched,
    output logic [2:0] LastResult,
    output logic       Reject,
    output logic       GameOver
);

    localparam int unsigned CELLS   = 100;
    localparam int unsigned IDX_W   = 7;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned SAT_MAX = 127;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               fire_prev_q, fire_prev_d;
    logic               score_this_q, score_this_d;
    logic [3:0]         shot_x_q, shot_x_d;
    logic [3:0]         shot_y_q, shot_y_d;
    logic               big_q, big_d;
    logic [1:0]         big_left_q, big_left_d;
    logic [CNT_W-1:0]   score_q, score_d;
    logic [CNT_W-1:0]   shots_q, shots_d;
    logic [4:0]         ships_q, ships_d;
    logic [2:0]         last_q, last_d;
    logic               reject_q, reject_d;
    logic               game_over_q, game_over_d;
    logic [CELLS-1:0]   fired_q, fired_d;

    logic               req;
    logic               coord_ok;
    logic               big_ok;
    logic               cell_free;
    logic               room_ok;
    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   shot_idx;
    logic [127:0]       fired_ext;
    logic [CNT_W:0]     score_sum;
    logic [CNT_W-1:0]   score_upd;
    logic [CNT_W-1:0]   shots_upd;
    logic [1:0]         big_left_upd;

    // Request qualification and result arithmetic
    always_comb begin
        req       = Fire & ~fire_prev_q;
        coord_ok  = (X >= 4'd1) && (X <= 4'd10) && (Y >= 4'd1) && (Y <= 4'd10);
        big_ok    = ~BigReq || (big_left_q != 2'd0);
        room_ok   = shots_q < CNT_W'(MAX_SHOTS);
        req_idx   = IDX_W'(({3'b000, X} - 7'd1) * 7'd10 + ({3'b000, Y} - 7'd1));
        shot_idx  = IDX_W'(({3'b000, shot_x_q} - 7'd1) * 7'd10 + ({3'b000, shot_y_q} - 7'd1));
        // Padded so out-of-range coordinates never index past the map
        fired_ext = {28'd0, fired_q};
        cell_free = ~fired_ext[req_idx];

        score_sum    = (CNT_W+1)'(score_q) + (CNT_W+1)'(TotalHits);
        score_upd    = (score_sum > (CNT_W+1)'(SAT_MAX)) ? CNT_W'(SAT_MAX) : score_sum[CNT_W-1:0];
        shots_upd    = shots_q + 7'd1;
        big_left_upd = (big_q && (big_left_q != 2'd0)) ? big_left_q - 2'd1 : big_left_q;
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        fire_prev_d  = Fire;
        shot_x_d     = shot_x_q;
        shot_y_d     = shot_y_q;
        big_d        = big_q;
        big_left_d   = big_left_q;
        score_d      = score_q;
        shots_d      = shots_q;
        ships_d      = ships_q;
        last_d       = last_q;
        reject_d     = 1'b0;
        fired_d      = fired_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (coord_ok && big_ok && cell_free && room_ok) begin
                        state_d  = ISSUE;
                        shot_x_d = X;
                        shot_y_d = Y;
                        big_d    = BigReq;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (SomethingIsWrong) begin
                    reject_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    shots_d           = shots_upd;
                    score_d           = score_upd;
                    big_left_d        = big_left_upd;
                    fired_d[shot_idx] = 1'b1;
                    ships_d           = ships_q | BiggestShipHit;
                    last_d            = {Hit, nearMiss, Miss};
                    if ((32'(score_upd) >= WIN_HITS) || (shots_upd == CNT_W'(MAX_SHOTS))) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are registered images of the state being entered
        score_this_d = (state_d == ISSUE);
        game_over_d  = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fire_prev_q  <= 1'b1;
            score_this_q <= 1'b0;
            shot_x_q     <= 4'd0;
            shot_y_q     <= 4'd0;
            big_q        <= 1'b0;
            big_left_q   <= 2'(BIG_BOMBS);
            score_q      <= '0;
            shots_q      <= '0;
            ships_q      <= 5'd0;
            last_q       <= 3'd0;
            reject_q     <= 1'b0;
            game_over_q  <= 1'b0;
            fired_q      <= '0;
        end else begin
            state_q      <= state_d;
            fire_prev_q  <= fire_prev_d;
            score_this_q <= score_this_d;
            shot_x_q     <= shot_x_d;
            shot_y_q     <= shot_y_d;
            big_q        <= big_d;
            big_left_q   <= big_left_d;
            score_q      <= score_d;
            shots_q      <= shots_d;
            ships_q      <= ships_d;
            last_q       <= last_d;
            reject_q     <= reject_d;
            game_over_q  <= game_over_d;
            fired_q      <= fired_d;
        end
    end

    assign ScoreThis    = score_this_q;
    assign ShotX        = shot_x_q;
    assign ShotY        = shot_y_q;
    assign Big          = big_q;
    assign BigLeft      = big_left_q;
    assign Score        = score_q;
    assign ShotsFired   = shots_q;
    assign ShipsTouched = ships_q;
    assign LastResult   = last_q;
    assign Reject       = reject_q;
    assign GameOver     = game_over_q;

endmodule

// File: tb/tb_battle_controller.sv
// Directed bench for battle_controller: a default-parameter instance plus a
// MAX_SHOTS=3 instance sharing the same stimulus.
module tb_battle_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] X, Y;
    logic       BigReq, Fire, Hit, nearMiss, Miss;
    logic [3:0] TotalHits;
    logic [4:0] BiggestShipHit;
    logic       SomethingIsWrong;

    logic       ScoreThis, Big, Reject, GameOver;
    logic [3:0] ShotX, ShotY;
    logic [1:0] BigLeft;
    logic [6:0] Score, ShotsFired;
    logic [4:0] ShipsTouched;
    logic [2:0] LastResult;

    logic       ScoreThis3, Big3, Reject3, GameOver3;
    logic [3:0] ShotX3, ShotY3;
    logic [1:0] BigLeft3;
    logic [6:0] Score3, ShotsFired3;
    logic [4:0] ShipsTouched3;
    logic [2:0] LastResult3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    battle_controller dut (
        .clock(clock), .reset(reset), .X(X), .Y(Y), .BigReq(BigReq), .Fire(Fire),
        .Hit(Hit), .nearMiss(nearMiss), .Miss(Miss), .TotalHits(TotalHits),
        .BiggestShipHit(BiggestShipHit), .SomethingIsWrong(SomethingIsWrong),
        .ScoreThis(ScoreThis), .ShotX(ShotX), .ShotY(ShotY), .Big(Big),
        .BigLeft(BigLeft), .Score(Score), .ShotsFired(ShotsFired),
        .ShipsTouched(ShipsTouched), .LastResult(LastResult), .Reject(Reject),
        .GameOver(GameOver)
    );

    battle_controller #(.MAX_SHOTS(3)) dut3 (
        .clock(clock), .reset(reset), .X(X), .Y(Y), .BigReq(BigReq), .Fire(Fire),
        .Hit(Hit), .nearMiss(nearMiss), .Miss(Miss), .TotalHits(TotalHits),
        .BiggestShipHit(BiggestShipHit), .SomethingIsWrong(SomethingIsWrong),
        .ScoreThis(ScoreThis3), .ShotX(ShotX3), .ShotY(ShotY3), .Big(Big3),
        .BigLeft(BigLeft3), .Score(Score3), .ShotsFired(ShotsFired3),
        .ShipsTouched(ShipsTouched3), .LastResult(LastResult3), .Reject(Reject3),
        .GameOver(GameOver3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fire(input logic [3:0] x, input logic [3:0] y, input logic big);
        X      = x;
        Y      = y;
        BigReq = big;
        Fire   = 1'b1;
        tick();
    endtask

    task automatic score(input logic [3:0] th, input logic [2:0] res, input logic [4:0] bsh,
                         input logic err);
        {Hit, nearMiss, Miss} = res;
        TotalHits        = th;
        BiggestShipHit   = bsh;
        SomethingIsWrong = err;
        tick();
    endtask

    task automatic rel();
        Fire                  = 1'b0;
        {Hit, nearMiss, Miss} = 3'b000;
        TotalHits             = 4'd0;
        BiggestShipHit        = 5'd0;
        SomethingIsWrong      = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        Fire  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        X = 4'd0; Y = 4'd0; BigReq = 1'b0; Fire = 1'b0;
        {Hit, nearMiss, Miss} = 3'b000;
        TotalHits = 4'd0; BiggestShipHit = 5'd0; SomethingIsWrong = 1'b0;
        tick();
        tick();
        check("rst_scorethis", 32'(ScoreThis), 32'd0);
        check("rst_bigleft", 32'(BigLeft), 32'd2);
        check("rst_score", 32'(Score), 32'd0);
        check("rst_shots", 32'(ShotsFired), 32'd0);
        check("rst_gameover", 32'(GameOver), 32'd0);
        check("rst_reject", 32'(Reject), 32'd0);
        reset = 1'b0;
        tick();

        // Single shot
        fire(4'd2, 4'd2, 1'b0);
        check("s1_strobe", 32'(ScoreThis), 32'd1);
        check("s1_shotx", 32'(ShotX), 32'd2);
        check("s1_shoty", 32'(ShotY), 32'd2);
        score(4'd1, 3'b100, 5'b01000, 1'b0);
        check("s1_strobe_off", 32'(ScoreThis), 32'd0);
        check("s1_score", 32'(Score), 32'd1);
        check("s1_shots", 32'(ShotsFired), 32'd1);
        check("s1_ships", 32'(ShipsTouched), 32'b01000);
        check("s1_last", 32'(LastResult), 32'b100);
        rel();

        // Out-of-range and duplicate requests
        fire(4'd0, 4'd5, 1'b0);
        check("x0_reject", 32'(Reject), 32'd1);
        check("x0_strobe", 32'(ScoreThis), 32'd0);
        tick();
        check("x0_reject_off", 32'(Reject), 32'd0);
        check("x0_shots", 32'(ShotsFired), 32'd1);
        check("x0_shotx_hold", 32'(ShotX), 32'd2);
        rel();
        fire(4'd11, 4'd3, 1'b0);
        check("x11_reject", 32'(Reject), 32'd1);
        rel();
        fire(4'd2, 4'd2, 1'b0);
        check("dup_reject", 32'(Reject), 32'd1);
        check("dup_strobe", 32'(ScoreThis), 32'd0);
        rel();
        fire(4'd10, 4'd10, 1'b0);
        check("corner_strobe", 32'(ScoreThis), 32'd1);
        score(4'd0, 3'b001, 5'd0, 1'b0);
        check("corner_shots", 32'(ShotsFired), 32'd2);
        check("corner_last", 32'(LastResult), 32'b001);
        rel();

        // Big-bomb exhaustion
        fire(4'd3, 4'd3, 1'b1);
        check("big1_flag", 32'(Big), 32'd1);
        score(4'd2, 3'b100, 5'b00010, 1'b0);
        check("big1_left", 32'(BigLeft), 32'd1);
        check("big1_score", 32'(Score), 32'd3);
        check("big1_ships", 32'(ShipsTouched), 32'b01010);
        rel();
        fire(4'd4, 4'd4, 1'b1);
        score(4'd2, 3'b100, 5'b00010, 1'b0);
        check("big2_left", 32'(BigLeft), 32'd0);
        check("big2_score", 32'(Score), 32'd5);
        check("big2_shots", 32'(ShotsFired), 32'd4);
        rel();
        fire(4'd5, 4'd5, 1'b1);
        check("big3_reject", 32'(Reject), 32'd1);
        check("big3_left", 32'(BigLeft), 32'd0);
        rel();

        // Scorer error leaves state untouched; same cell may be re-fired
        fire(4'd6, 4'd6, 1'b0);
        check("err_strobe", 32'(ScoreThis), 32'd1);
        score(4'd3, 3'b100, 5'b10000, 1'b1);
        check("err_reject", 32'(Reject), 32'd1);
        check("err_score", 32'(Score), 32'd5);
        check("err_shots", 32'(ShotsFired), 32'd4);
        check("err_ships", 32'(ShipsTouched), 32'b01010);
        rel();
        check("err_reject_off", 32'(Reject), 32'd0);
        fire(4'd6, 4'd6, 1'b0);
        check("refire_strobe", 32'(ScoreThis), 32'd1);
        score(4'd0, 3'b010, 5'd0, 1'b0);
        check("refire_shots", 32'(ShotsFired), 32'd5);
        check("refire_last", 32'(LastResult), 32'b010);
        rel();

        // Shot limit on the MAX_SHOTS=3 instance
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            fire(4'd1, 4'(i), 1'b0);
            score(4'd0, 3'b001, 5'd0, 1'b0);
            check("lim_shots", 32'(ShotsFired3), 32'(i));
            check("lim_gameover", 32'(GameOver3), (i == 3) ? 32'd1 : 32'd0);
            rel();
        end
        fire(4'd1, 4'd4, 1'b0);
        check("lim_fire4_strobe", 32'(ScoreThis3), 32'd0);
        check("lim_fire4_reject", 32'(Reject3), 32'd0);
        tick();
        check("lim_fire4_reject2", 32'(Reject3), 32'd0);
        check("lim_shots_final", 32'(ShotsFired3), 32'd3);
        rel();

        // Winning score 18 -> 19
        do_reset();
        fire(4'd7, 4'd7, 1'b0);
        score(4'd9, 3'b100, 5'b00001, 1'b0);
        rel();
        fire(4'd8, 4'd8, 1'b0);
        score(4'd9, 3'b100, 5'b00001, 1'b0);
        check("win18_score", 32'(Score), 32'd18);
        check("win18_gameover", 32'(GameOver), 32'd0);
        rel();
        fire(4'd8, 4'd9, 1'b0);
        score(4'd1, 3'b100, 5'b00001, 1'b0);
        check("win19_score", 32'(Score), 32'd19);
        check("win19_gameover", 32'(GameOver), 32'd1);
        rel();
        fire(4'd1, 4'd1, 1'b0);
        check("done_strobe", 32'(ScoreThis), 32'd0);
        check("done_reject", 32'(Reject), 32'd0);
        rel();

        // Reset during ISSUE with Fire held high
        do_reset();
        fire(4'd9, 4'd9, 1'b1);
        check("mid_strobe", 32'(ScoreThis), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_strobe", 32'(ScoreThis), 32'd0);
        check("mid_rst_shotx", 32'(ShotX), 32'd0);
        check("mid_rst_big", 32'(Big), 32'd0);
        check("mid_rst_bigleft", 32'(BigLeft), 32'd2);
        tick();
        reset = 1'b0;
        tick();
        check("mid_hold_strobe", 32'(ScoreThis), 32'd0);
        tick();
        check("mid_hold_strobe2", 32'(ScoreThis), 32'd0);
        check("mid_hold_shots", 32'(ShotsFired), 32'd0);
        rel();
        fire(4'd9, 4'd9, 1'b0);
        check("mid_refire_strobe", 32'(ScoreThis), 32'd1);
        score(4'd0, 3'b001, 5'd0, 1'b0);
        check("mid_refire_shots", 32'(ShotsFired), 32'd1);
        rel();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
